// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: clears DMEM after reset, then shares it between the CPU (priority) and a
// read-only debug port with starvation protection. Define DMEM_ARB_STATS_EN to add access counters.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 2048,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              init_done
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_acc,
    output logic [15:0]       stat_dbg_acc,
    output logic [15:0]       stat_stall
`endif
);

    localparam int WC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_DBG_RD} owner_t;

    state_t            r_state, w_state_nxt;
    owner_t            r_owner, w_owner_nxt;
    logic [ADDR_W-1:0] r_init_addr;
    logic [WC_W-1:0]   r_wait_cnt;
    logic              w_init_last;
    logic              w_dbg_force;
    logic              w_dbg_win;
    logic              w_cpu_win;

    assign w_init_last = (r_init_addr == ADDR_W'(DEPTH - 1));
    assign w_dbg_force = (r_state == S_RUN) && dbg_req && (r_wait_cnt == WC_W'(STARVE_LIMIT));
    assign w_dbg_win   = w_dbg_force || ((r_state == S_RUN) && !cpu_req && dbg_req);
    assign w_cpu_win   = (r_state == S_RUN) && cpu_req && !w_dbg_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && w_init_last) w_state_nxt = S_RUN;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = cpu_req;
        dbg_gnt   = 1'b0;
        case (r_state)
            S_INIT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_init_addr;
                mem_wdata = '0;
            end
            S_RUN: begin
                if (w_dbg_win) begin
                    mem_en   = 1'b1;
                    dbg_gnt  = 1'b1;
                    mem_addr = dbg_addr;
                end else if (w_cpu_win) begin
                    mem_en    = 1'b1;
                    mem_we    = cpu_we;
                    cpu_stall = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Read ownership is captured at issue so the returning word is steered to the right port.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_dbg_win)                 w_owner_nxt = OWN_DBG_RD;
        else if (w_cpu_win && !cpu_we) w_owner_nxt = OWN_CPU_RD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_addr <= '0;
            r_wait_cnt  <= '0;
            r_owner     <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
            if (r_state == S_INIT) begin
                r_init_addr <= r_init_addr + ADDR_W'(1);
                r_wait_cnt  <= '0;
            end else if (!dbg_req || w_dbg_win) begin
                r_wait_cnt  <= '0;
            end else if (r_wait_cnt != WC_W'(STARVE_LIMIT)) begin
                r_wait_cnt  <= r_wait_cnt + WC_W'(1);
            end
        end
    end

    assign init_done  = (r_state == S_RUN);
    assign cpu_rvalid = (r_owner == OWN_CPU_RD);
    assign dbg_rvalid = (r_owner == OWN_DBG_RD);
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_acc <= '0;
            stat_dbg_acc <= '0;
            stat_stall   <= '0;
        end else if (r_state == S_RUN) begin
            if (w_cpu_win) stat_cpu_acc <= sat_inc(stat_cpu_acc);
            if (w_dbg_win) stat_dbg_acc <= sat_inc(stat_dbg_acc);
            if (cpu_stall) stat_stall   <= sat_inc(stat_stall);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: DMEM model, table of RUN vectors with a read-data scoreboard,
// and hand sequences for the clear sweep, starvation pattern and asynchronous reset.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cpu_req, cpu_we, dbg_req;
    logic [10:0] cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, init_done;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_acc, stat_dbg_acc, stat_stall;
`endif

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .init_done(init_done)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_acc(stat_cpu_acc), .stat_dbg_acc(stat_dbg_acc), .stat_stall(stat_stall)
`endif
    );

    // Single-port DMEM with one-cycle read latency, preloaded with non-zero garbage.
    logic [31:0] dmem [0:2047];
    initial for (int i = 0; i < 2048; i++) dmem[i] = 32'hA500_0000 | i;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= dmem[mem_addr];
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        bit creq, cwe; logic [10:0] caddr; logic [31:0] cwd; bit dreq; logic [10:0] daddr;
        bit e_stall, e_gnt, e_en, e_we; logic [10:0] e_addr; bit e_crd, e_drd; logic [31:0] e_data;
    } vec_t;

    typedef struct { bit is_dbg; logic [31:0] data; } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    function automatic vec_t mkv(bit creq, bit cwe, logic [10:0] caddr, logic [31:0] cwd,
                                 bit dreq, logic [10:0] daddr, bit st, bit gn, bit en, bit we,
                                 logic [10:0] ea, bit crd, bit drd, logic [31:0] ed);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd; v.dreq = dreq; v.daddr = daddr;
        v.e_stall = st; v.e_gnt = gn; v.e_en = en; v.e_we = we; v.e_addr = ea;
        v.e_crd = crd; v.e_drd = drd; v.e_data = ed;
        return v;
    endfunction

    // Checks n clear writes from address 0, starting at the next falling edge.
    task automatic init_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("init_a%0d", i),
                {mem_en, mem_we, cpu_stall, dbg_gnt, init_done, mem_addr, mem_wdata},
                {5'b11100, 11'(i), 32'h0});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [10:0] A = 11'h010, B = 11'h020, F = 11'h7FF;
    localparam logic [31:0] D = 32'hDEADBEEF, E = 32'h12345678;

    initial begin
        vec_t v;
        sb_t  s;
        bit   pend_c, pend_d;

        vecs.push_back(mkv(1, 1, A, D, 0, 0, 0, 0, 1, 1, A, 0, 0, 0));
        vecs.push_back(mkv(1, 0, A, 0, 0, 0, 0, 0, 1, 0, A, 1, 0, D));
        vecs.push_back(mkv(0, 0, 0, 0, 1, F, 0, 1, 1, 0, F, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) vecs.push_back(mkv(1, 0, A, 0, 1, A, 0, 0, 1, 0, A, 1, 0, D));
            vecs.push_back(mkv(1, 0, A, 0, 1, A, 1, 1, 1, 0, A, 0, 1, D));
        end
        vecs.push_back(mkv(1, 1, B, E, 1, F, 0, 0, 1, 1, B, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, B, 0, 1, 1, 0, B, 0, 1, E));
        vecs.push_back(mkv(1, 0, B, 0, 0, 0, 0, 0, 1, 0, B, 1, 0, E));
        for (int j = 0; j < 3; j++) vecs.push_back(mkv(1, 0, A, 0, 1, F, 0, 0, 1, 0, A, 1, 0, D));
        vecs.push_back(mkv(1, 0, A, 0, 0, 0, 0, 0, 1, 0, A, 1, 0, D));
        for (int j = 0; j < 4; j++) vecs.push_back(mkv(1, 0, A, 0, 1, F, 0, 0, 1, 0, A, 1, 0, D));
        vecs.push_back(mkv(1, 0, A, 0, 1, F, 1, 1, 1, 0, F, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b1; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_cpu_stall", cpu_stall, 1);

        rst_n = 1'b1;
        init_sweep(2048);
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        chk("done_after_clear", {init_done, mem_en}, {1'b1, 1'b0});

        pend_c = 1'b0; pend_d = 1'b0;
        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
            dbg_req = v.dreq; dbg_addr = v.daddr;
            #1;
            chk($sformatf("v%0d_ctl", k), {cpu_stall, dbg_gnt, mem_en, mem_we},
                {v.e_stall, v.e_gnt, v.e_en, v.e_we});
            if (v.e_en) chk($sformatf("v%0d_addr", k), mem_addr, v.e_addr);
            if (v.e_we) chk($sformatf("v%0d_wdata", k), mem_wdata, v.cwd);
            chk($sformatf("v%0d_rvalid", k), {cpu_rvalid, dbg_rvalid}, {pend_c, pend_d});
            if ((cpu_rvalid || dbg_rvalid) && sb.size() > 0) begin
                s = sb.pop_front();
                chk($sformatf("v%0d_rport", k), dbg_rvalid, s.is_dbg);
                chk($sformatf("v%0d_rdata", k), dbg_rvalid ? dbg_rdata : cpu_rdata, s.data);
            end
            if (v.e_crd || v.e_drd) sb.push_back('{v.e_drd, v.e_data});
            pend_c = v.e_crd; pend_d = v.e_drd;
            @(negedge clk);
        end
        chk("sb_empty", sb.size(), 0);

        // Reset with a CPU load in flight: rvalid must drop at once.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = A; dbg_req = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight_rvalid", cpu_rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", {cpu_rvalid, init_done}, 2'b00);
        chk("async_rst_addr", {mem_we, mem_addr}, {1'b1, 11'h000});

        dbg_req = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        init_sweep(1001);
        rst_n = 1'b0;
        #1;
        chk("midinit_rst_addr", mem_addr, 11'h000);
        chk("midinit_rst_ctl", {cpu_stall, dbg_gnt, init_done, cpu_rvalid, dbg_rvalid}, 5'b10000);

        @(posedge clk);
        #1 rst_n = 1'b1;
        init_sweep(2048);
        cpu_we = 1'b0; cpu_addr = A; dbg_addr = F;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d", k), {dbg_gnt, cpu_stall, mem_addr},
                {(k % 5 == 4), (k % 5 == 4), (k % 5 == 4) ? F : A});
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_cpu_acc", stat_cpu_acc, 16);
        chk("stat_dbg_acc", stat_dbg_acc, 4);
        chk("stat_stall", stat_stall, 4);
`endif
        chk("idle_after_starve", {mem_en, dbg_gnt, cpu_stall}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
